bcd_frequency_generator: RTL and testbench
==========================================

Name: bcd_frequency_generator

Overview:
- Transmit-side counterpart of the frequency meter: takes a 4-digit BCD frequency setpoint in Hz, the same format the meter reports, and generates a square wave at that frequency.
- Sequential BCD-to-binary converter feeding a fractional (phase-accumulator) toggle generator.
- Sits in the signal-source path; its output can drive the meter's Fxin for loopback self-test.

Parameters:
- CLK_HZ, 100_000_000, Clk frequency in Hz. HALF = CLK_HZ/2; HALF must be > 9999.
- ACC_W, $clog2(CLK_HZ/2 + 10000), phase accumulator width.

Ports:
- Clk  input  1  system clock; all logic on posedge.
- Rst_n  input  1  asynchronous active-low reset.
- Frequency_BCD  input  16  setpoint, 4 BCD digits, [15:12] = thousands, range 0..9999 Hz.
- Load  input  1  single-cycle strobe; samples Frequency_BCD.
- Busy  output  1  conversion in progress; Load ignored while high.
- Bcd_Error  output  1  last Load carried a nibble > 9; sticky.
- Freq_Binary  output  14  active frequency in binary.
- Fx_out  output  1  generated square wave, registered.

Behaviour:
- Reset (async assert, Rst_n low): Busy=0, Bcd_Error=0, Freq_Binary=0, Fx_out=0, accumulator=0, state=IDLE.
- States:
  - IDLE: Load=1 with all nibbles ≤ 9 → capture BCD, clear binary scratch, digit index=3, Busy<=1, Bcd_Error<=0, go to CONV. Load=1 with any nibble > 9 → Bcd_Error<=1, stay in IDLE; Busy, Freq_Binary and generation are unaffected.
  - CONV: 4 edges, one digit per edge, MSD first: scratch <= scratch*10 + digit[index]. Use 14-bit arithmetic; the maximum is 9999, so there is no overflow. Go to APPLY after index 0.
  - APPLY: one edge. Freq_Binary<=scratch, accumulator<=0, Fx_out<=0, Busy<=0, go to IDLE.
- Latency: Load sampled at edge k → Busy high after edge k through edge k+5. Freq_Binary is new after edge k+5, and Busy reads 0 after edge k+5.
- Load while Busy is ignored, with no error flag. The old frequency keeps generating during CONV until APPLY.
- Generator runs every edge except APPLY:
  - Freq_Binary = 0: accumulator held at 0, Fx_out held at 0.
  - Otherwise: s = acc + Freq_Binary. If s ≥ HALF: acc <= s − HALF and Fx_out toggles. Else acc <= s.
  - Result: average Fx_out frequency is exactly Freq_Binary Hz. Per-edge jitter is ≤ 1 Clk period. At most one toggle per edge.
- The first Fx_out rising edge after APPLY comes ceil(HALF/Freq_Binary) edges after the APPLY edge.
- Rst_n asserted mid-CONV: conversion aborted, all state and outputs go to reset values immediately. After release the block is in IDLE with Freq_Binary=0.
- Deassertion of Rst_n is assumed synchronised upstream.

Test Plan (CLK_HZ=20_000, HALF=10000):
- Reset: hold Rst_n low, apply Load pulses and toggle Frequency_BCD → all outputs stay 0. Release → Fx_out stays 0 (Freq_Binary=0).
- Load 16'h1000 → Busy high for exactly 5 edges; Freq_Binary=1000 at k+5. Fx_out first rises 10 edges after APPLY, then toggles every 10 edges (period 20).
- Load 16'h3000 → Freq_Binary=3000. Toggle spacing repeats 4,3,3 edges, giving 3 toggles per 10 edges.
- Load 16'h9999 → Freq_Binary=14'h270F; Fx_out toggles on 9999 of every 10000 edges.
- Load 16'h12A4 → Bcd_Error=1 next edge, Busy stays 0, Freq_Binary and Fx_out unchanged. A following valid Load clears Bcd_Error.
- Load 16'h0500, then Load 16'h0700 two edges later (while Busy) → second Load ignored, Freq_Binary=500. Then Load 16'h0000 → after APPLY, Fx_out=0 and stays 0.
- Assert Rst_n at the third CONV edge → immediate clear. After release Busy=0 and no APPLY occurs.

Source files
------------

// File: rtl/bcd_frequency_generator.sv
// BCD setpoint to square-wave generator: sequential BCD-to-binary conversion feeding a
// phase-accumulator toggle generator whose average output frequency equals the setpoint in Hz.
module bcd_frequency_generator #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned ACC_W  = $clog2(CLK_HZ / 2 + 10000)
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [15:0] Frequency_BCD,
    input  logic        Load,
    output logic        Busy,
    output logic        Bcd_Error,
    output logic [13:0] Freq_Binary,
    output logic        Fx_out
);

    localparam logic [ACC_W-1:0] HALF = ACC_W'(CLK_HZ / 2);

    typedef enum logic [1:0] {StIdle, StConv, StApply} state_e;

    state_e           state_q;
    logic [15:0]      bcd_q;
    logic [13:0]      scratch_q;
    logic [1:0]       idx_q;
    logic             busy_q;
    logic             err_q;
    logic [13:0]      freq_q;
    logic [ACC_W-1:0] acc_q;
    logic             fx_q;

    logic             bcd_bad;
    logic [ACC_W-1:0] sum;
    logic [13:0]      scratch_next;

    always_comb begin
        bcd_bad = (Frequency_BCD[15:12] > 4'd9) || (Frequency_BCD[11:8] > 4'd9) ||
                  (Frequency_BCD[7:4] > 4'd9) || (Frequency_BCD[3:0] > 4'd9);
        // acc < HALF and freq <= 9999, so the sum always fits in ACC_W bits.
        sum          = acc_q + ACC_W'(freq_q);
        scratch_next = scratch_q * 14'd10 + {10'd0, bcd_q[15:12]};
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= StIdle;
            bcd_q     <= '0;
            scratch_q <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            freq_q    <= '0;
            acc_q     <= '0;
            fx_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (Load) begin
                        if (bcd_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            bcd_q     <= Frequency_BCD;
                            scratch_q <= '0;
                            idx_q     <= 2'd3;
                            busy_q    <= 1'b1;
                            err_q     <= 1'b0;
                            state_q   <= StConv;
                        end
                    end
                end
                StConv: begin
                    // Most significant digit is always in the top nibble of the shifted copy.
                    scratch_q <= scratch_next;
                    bcd_q     <= {bcd_q[11:0], 4'h0};
                    idx_q     <= idx_q - 2'd1;
                    if (idx_q == 2'd0) begin
                        state_q <= StApply;
                    end
                end
                StApply: begin
                    freq_q  <= scratch_q;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            if (state_q == StApply || freq_q == 14'd0) begin
                acc_q <= '0;
                fx_q  <= 1'b0;
            end else if (sum >= HALF) begin
                acc_q <= sum - HALF;
                fx_q  <= ~fx_q;
            end else begin
                acc_q <= sum;
            end
        end
    end

    assign Busy        = busy_q;
    assign Bcd_Error   = err_q;
    assign Freq_Binary = freq_q;
    assign Fx_out      = fx_q;

endmodule

// File: tb/tb_bcd_frequency_generator.sv
// Scoreboard bench for bcd_frequency_generator at CLK_HZ=20000 (HALF=10000).
module tb_bcd_frequency_generator;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic [15:0] Frequency_BCD = 16'h0000;
    logic        Load = 1'b0;
    logic        Busy;
    logic        Bcd_Error;
    logic [13:0] Freq_Binary;
    logic        Fx_out;

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    bcd_frequency_generator #(.CLK_HZ(20_000)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Frequency_BCD(Frequency_BCD),
        .Load         (Load),
        .Busy         (Busy),
        .Bcd_Error    (Bcd_Error),
        .Freq_Binary  (Freq_Binary),
        .Fx_out       (Fx_out)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every completed conversion (Busy falling outside reset) pops one expectation.
    logic prev_busy = 1'b0;
    always @(negedge Clk) begin
        if (Rst_n && prev_busy && !Busy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_apply", 1, 0);
            end else begin
                check("freq_binary", int'(Freq_Binary), exp_q.pop_front());
            end
        end
        prev_busy <= Busy;
    end

    task automatic pulse_load(input logic [15:0] bcd);
        @(negedge Clk);
        Load = 1'b1;
        Frequency_BCD = bcd;
        @(negedge Clk);
        Load = 1'b0;
    endtask

    // Counts sampled cycles with Busy high, ending at the negedge after APPLY.
    task automatic wait_idle(output int n);
        n = 0;
        while (Busy && n < 20) begin
            n++;
            @(negedge Clk);
        end
        if (Busy) check("busy_timeout", 1, 0);
    endtask

    task automatic next_toggle(output int gap);
        logic prev;
        prev = Fx_out;
        gap = 0;
        while (gap < 100) begin
            @(negedge Clk);
            gap++;
            if (Fx_out != prev) break;
        end
    endtask

    task automatic count_toggles(input int edges, output int cnt);
        logic prev;
        prev = Fx_out;
        cnt = 0;
        for (int i = 0; i < edges; i++) begin
            @(negedge Clk);
            if (Fx_out != prev) cnt++;
            prev = Fx_out;
        end
    endtask

    int n, g, c;
    int gaps3000[6] = '{4, 3, 3, 4, 3, 3};

    initial begin
        #2 Rst_n = 1'b0;
        // Reset held: Load and data activity must not disturb anything.
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            Load = i[0];
            Frequency_BCD = (i[0]) ? 16'h1234 : 16'h9999;
            @(negedge Clk);
            check("rst_outputs", {Busy, Bcd_Error, Fx_out, Freq_Binary}, 0);
        end
        Load = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        count_toggles(20, c);
        check("rst_release_toggles", c, 0);
        check("rst_release_freq", int'(Freq_Binary), 0);

        // 1000 Hz: 5-cycle Busy, first rise 10 edges after APPLY, then every 10 edges.
        exp_q.push_back(1000);
        pulse_load(16'h1000);
        wait_idle(n);
        check("busy_cycles_1000", n, 5);
        next_toggle(g);
        check("first_rise_1000", g, 10);
        check("first_rise_level", int'(Fx_out), 1);
        for (int i = 0; i < 3; i++) begin
            next_toggle(g);
            check("gap_1000", g, 10);
        end

        // 3000 Hz: toggle spacing 4,3,3 repeating.
        exp_q.push_back(3000);
        pulse_load(16'h3000);
        wait_idle(n);
        check("busy_cycles_3000", n, 5);
        for (int i = 0; i < 6; i++) begin
            next_toggle(g);
            check("gap_3000", g, gaps3000[i]);
        end

        // 9999 Hz: 9999 toggles in 10000 edges.
        exp_q.push_back(9999);
        pulse_load(16'h9999);
        wait_idle(n);
        count_toggles(10000, c);
        check("toggles_9999", c, 9999);

        // Invalid nibble: sticky error, no conversion, generation continues.
        pulse_load(16'h12A4);
        check("err_set", int'(Bcd_Error), 1);
        check("err_busy", int'(Busy), 0);
        check("err_freq_kept", int'(Freq_Binary), 9999);
        count_toggles(100, c);
        check("err_gen_running", int'(c >= 99 && c <= 100), 1);
        check("err_sticky", int'(Bcd_Error), 1);

        // Valid load clears error; a second Load while Busy is ignored.
        exp_q.push_back(500);
        pulse_load(16'h0500);
        check("err_cleared", int'(Bcd_Error), 0);
        check("busy_500", int'(Busy), 1);
        Load = 1'b1;
        Frequency_BCD = 16'h0700;
        @(negedge Clk);
        Load = 1'b0;
        wait_idle(n);
        check("busy_ignored_err", int'(Bcd_Error), 0);
        count_toggles(60, c);
        check("no_extra_apply", int'(Freq_Binary), 500);

        // Zero setpoint: output parks low.
        exp_q.push_back(0);
        pulse_load(16'h0000);
        wait_idle(n);
        check("zero_fx", int'(Fx_out), 0);
        count_toggles(50, c);
        check("zero_toggles", c, 0);

        // Reset mid-conversion: abort, clear, no APPLY afterwards.
        exp_q.push_back(200);
        pulse_load(16'h0200);
        wait_idle(n);
        pulse_load(16'h1000);
        @(negedge Clk);
        @(negedge Clk);
        #1 Rst_n = 1'b0;
        #1 check("midrst_outputs", {Busy, Bcd_Error, Fx_out, Freq_Binary}, 0);
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        count_toggles(10, c);
        check("midrst_busy", int'(Busy), 0);
        check("midrst_freq", int'(Freq_Binary), 0);
        check("midrst_toggles", c, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1);
    end

endmodule
